// File: rtl/spi_slave_fifo_if.sv
// Host-side bus of spi_slave_fifo: TX write channel, RX read channel and FIFO levels.
interface spi_slave_fifo_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIFO_AW = 2
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic [FIFO_AW:0]  tx_level;
  logic [FIFO_AW:0]  rx_level;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data, tx_level, rx_level
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data, tx_level, rx_level
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX FIFOs; SPI pins are oversampled in the sys_clk_i domain.
// Define SPI_SLV_FRAME_ERR_EN to build the partial-frame error detector on frame_err.
module spi_slave_fifo #(
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       FIFO_DEPTH    = 4,
  parameter int unsigned       FIFO_AW       = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_WORD = '0
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic sck_i,
  input  logic ssn_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  input  logic slave_mode,
  input  logic cpol,
  input  logic cpha,
  input  logic lsb_first,
  spi_slave_fifo_if.slave host,
  output logic rx_overflow,
  output logic tx_underrun,
  output logic frame_err,
  output logic busy
);
  localparam int unsigned      CntW     = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0]  WordBits = CntW'(DATA_W);
  localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_W - 1);
  localparam logic [FIFO_AW:0] Depth    = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              reload_pend_q, skip_q;
  logic [DATA_W-1:0] tx_shift_q, rx_shift_q;

  logic sck_s1, sck_s2, sck_s3, ssn_s1, ssn_s2, ssn_s3, mosi_s1, mosi_s2;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      {sck_s1, sck_s2, sck_s3} <= {3{cpol}};
      {ssn_s1, ssn_s2, ssn_s3} <= 3'b111;
      {mosi_s1, mosi_s2}       <= 2'b00;
    end else begin
      {sck_s1, sck_s2, sck_s3} <= {sck_i, sck_s1, sck_s2};
      {ssn_s1, ssn_s2, ssn_s3} <= {ssn_i, ssn_s1, ssn_s2};
      {mosi_s1, mosi_s2}       <= {mosi_i, mosi_s1};
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, abort, ssn_fall;
  assign lead_edge   = (sck_s3 == cpol) && (sck_s2 != cpol);
  assign trail_edge  = (sck_s3 != cpol) && (sck_s2 == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign abort       = ssn_s2 || !slave_mode;
  assign ssn_fall    = ssn_s3 && !ssn_s2;

  // FIFO storage and occupancy
  logic [DATA_W-1:0]  tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  rx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [FIFO_AW:0]   tx_level_q, rx_level_q;
  logic               tx_empty, tx_full, rx_empty, rx_full;
  logic               tx_push, tx_pop, rx_push, rx_pop;
  logic               load_req, rx_push_req;
  logic [DATA_W-1:0]  load_word, rx_next;

  assign tx_empty  = (tx_level_q == '0);
  assign tx_full   = (tx_level_q == Depth);
  assign rx_empty  = (rx_level_q == '0);
  assign rx_full   = (rx_level_q == Depth);
  assign load_word = tx_empty ? UNDERRUN_WORD : tx_mem[tx_rd_q];
  assign rx_next   = lsb_first ? {mosi_s2, rx_shift_q[DATA_W-1:1]}
                               : {rx_shift_q[DATA_W-2:0], mosi_s2};

  // A TX word is taken once on entry (LOAD) and again on the shift edge after a full word.
  assign load_req    = !abort && ((state_q == StLoad) ||
                       ((state_q == StShift) && shift_edge && reload_pend_q));
  assign rx_push_req = !abort && (state_q == StShift) && sample_edge && !reload_pend_q &&
                       (bit_cnt_q == LastBit);

  assign tx_push = host.tx_valid && !tx_full;
  assign tx_pop  = load_req && !tx_empty;
  assign rx_push = rx_push_req && !rx_full;
  assign rx_pop  = host.rx_ready && !rx_empty;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_q] <= host.tx_data;
        tx_wr_q         <= tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) begin
        rx_mem[rx_wr_q] <= rx_next;
        rx_wr_q         <= rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push_req && rx_full) rx_overflow <= 1'b1;
      tx_level_q <= tx_level_q + {{FIFO_AW{1'b0}}, tx_push} - {{FIFO_AW{1'b0}}, tx_pop};
      rx_level_q <= rx_level_q + {{FIFO_AW{1'b0}}, rx_push} - {{FIFO_AW{1'b0}}, rx_pop};
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      reload_pend_q <= 1'b0;
      skip_q        <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      tx_underrun   <= 1'b0;
    end else begin
      if (load_req && tx_empty) tx_underrun <= 1'b1;
      if (abort) begin
        state_q       <= StIdle;
        bit_cnt_q     <= '0;
        reload_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: if (ssn_fall) state_q <= StLoad;
          StLoad: begin
            tx_shift_q    <= load_word;
            bit_cnt_q     <= '0;
            reload_pend_q <= 1'b0;
            skip_q        <= cpha;  // cpha=1: first leading edge only presents the word
            state_q       <= StShift;
          end
          StShift: begin
            if (sample_edge && !reload_pend_q) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LastBit) reload_pend_q <= 1'b1;
            end else if (shift_edge) begin
              if (reload_pend_q) begin
                tx_shift_q    <= load_word;
                bit_cnt_q     <= '0;
                reload_pend_q <= 1'b0;
              end else if (skip_q) begin
                skip_q <= 1'b0;
              end else begin
                tx_shift_q <= lsb_first ? (tx_shift_q >> 1) : (tx_shift_q << 1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) frame_err_q <= 1'b0;
    else frame_err_q <= abort && (state_q != StIdle) && (bit_cnt_q != '0) &&
                        (bit_cnt_q != WordBits);
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign busy          = (state_q != StIdle);
  assign miso_oe_o     = busy;
  assign miso_o        = busy && (lsb_first ? tx_shift_q[0] : tx_shift_q[DATA_W-1]);
  assign host.tx_ready = !tx_full;
  assign host.rx_valid = !rx_empty;
  assign host.rx_data  = rx_empty ? '0 : rx_mem[rx_rd_q];
  assign host.tx_level = tx_level_q;
  assign host.rx_level = rx_level_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Scoreboard bench for spi_slave_fifo: a bit-level SPI master plus a queue model of both FIFOs.
module tb_spi_slave_fifo;
  localparam int HALF  = 6;
  localparam int DEPTH = 4;
`ifdef SPI_SLV_FRAME_ERR_EN
  localparam int ExpFe = 1;
`else
  localparam int ExpFe = 0;
`endif

  logic clk = 1'b0;
  logic rst, sck, ssn, mosi, miso, miso_oe, slave_mode, cpol, cpha, lsb_first;
  logic rx_overflow, tx_underrun, frame_err, busy;

  spi_slave_fifo_if #(.DATA_W(8), .FIFO_AW(2)) host_if ();

  spi_slave_fifo #(
    .DATA_W(8), .FIFO_DEPTH(4), .FIFO_AW(2), .UNDERRUN_WORD(8'hFF)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .sck_i(sck), .ssn_i(ssn), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .slave_mode(slave_mode), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .host(host_if), .rx_overflow(rx_overflow),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;

  // Reference model: queue contents of both FIFOs and the sticky flags.
  logic [7:0] tx_model [$];
  logic [7:0] exp_rx [$];
  logic       exp_underrun = 1'b0;
  logic       exp_overflow = 1'b0;
  logic [7:0] mw [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_load();
    if (tx_model.size() > 0) return tx_model.pop_front();
    exp_underrun = 1'b1;
    return 8'hFF;
  endfunction

  // Host-side monitor: every RX pop must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && host_if.rx_valid && host_if.rx_ready) begin
      if (exp_rx.size() == 0) chk("rx_unexpected_pop", host_if.rx_data, 32'hDEAD);
      else chk("rx_data", host_if.rx_data, exp_rx.pop_front());
    end
    if (frame_err) fe_cnt++;
  end

  task automatic half();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // Waits half an SCK period after a sample edge; on a word boundary updates the RX model
  // and measures how many cycles rx_valid takes to appear.
  task automatic after_sample(input bit last, input logic [7:0] word);
    int lat;
    bit check_lat;
    lat = 0;
    check_lat = 1'b0;
    if (last) begin
      if (exp_rx.size() < DEPTH) begin
        exp_rx.push_back(word);
        check_lat = host_if.rx_ready;
      end else begin
        exp_overflow = 1'b1;
      end
    end
    for (int c = 1; c <= HALF; c++) begin
      @(negedge clk);
      if (host_if.rx_valid && lat == 0) lat = c;
      @(posedge clk);
    end
    #1;
    if (check_lat) chk("rx_latency", lat, 4);
  endtask

  task automatic host_write(input logic [7:0] w);
    @(posedge clk); #1;
    host_if.tx_valid = 1'b1;
    host_if.tx_data  = w;
    @(negedge clk);
    chk("tx_ready", host_if.tx_ready, (tx_model.size() < DEPTH));
    @(posedge clk); #1;
    host_if.tx_valid = 1'b0;
    if (tx_model.size() < DEPTH) tx_model.push_back(w);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    @(posedge clk); #1;
    cpol = pol; cpha = pha; lsb_first = lsb; sck = pol;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_idle();
    chk("busy_idle", busy, 0);
    chk("oe_idle", miso_oe, 0);
    chk("miso_idle", miso, 0);
    chk("tx_underrun", tx_underrun, exp_underrun);
    chk("rx_overflow", rx_overflow, exp_overflow);
    chk("tx_level", host_if.tx_level, tx_model.size());
  endtask

  // Master: shifts nwords from mw[]; stop_bits>0 raises ssn after that many bits of word 0.
  task automatic run_frame(input int nwords, input int stop_bits);
    logic [7:0] exp_w, got;
    int nb, idx;
    @(posedge clk); #1;
    ssn = 1'b0;
    mosi = 1'b0;
    exp_w = model_load();
    repeat (8) @(posedge clk);
    #1;
    chk("busy_frame", busy, 1);
    chk("oe_frame", miso_oe, 1);
    nb = (stop_bits > 0) ? stop_bits : 8;
    for (int w = 0; w < nwords; w++) begin
      got = '0;
      for (int b = 0; b < nb; b++) begin
        idx = lsb_first ? b : 7 - b;
        if (!cpha) begin
          mosi = mw[w][idx];
          half();
          sck = ~cpol;
          got[idx] = miso;
          after_sample(stop_bits == 0 && b == 7, mw[w]);
          sck = cpol;
        end else begin
          sck = ~cpol;
          mosi = mw[w][idx];
          half();
          sck = cpol;
          got[idx] = miso;
          after_sample(stop_bits == 0 && b == 7, mw[w]);
        end
      end
      if (stop_bits == 0) begin
        chk("miso_word", got, exp_w);
        if (w < nwords - 1 || !cpha) exp_w = model_load();
      end
    end
    half();
    ssn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_idle();
  endtask

  task automatic check_reset_vals();
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_tx_ready", host_if.tx_ready, 1);
    chk("rst_rx_valid", host_if.rx_valid, 0);
    chk("rst_rx_data", host_if.rx_data, 0);
    chk("rst_tx_level", host_if.tx_level, 0);
    chk("rst_rx_level", host_if.rx_level, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sck = 1'b0; ssn = 1'b1; mosi = 1'b0; slave_mode = 1'b1;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    host_if.tx_valid = 1'b0; host_if.tx_data = '0; host_if.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    // Mode 3, LSB first: fill TX past full, drain with a 4-word frame, then underrun.
    set_mode(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) host_write(8'($urandom_range(0, 255)));
    chk("tx_level_full", host_if.tx_level, 4);
    for (int i = 0; i < 4; i++) mw[i] = 8'($urandom_range(0, 255));
    run_frame(4, 0);
    mw[0] = 8'($urandom_range(0, 255));
    run_frame(1, 0);

    // Mode 0, MSB first: A5 out, 3C in.
    set_mode(1'b0, 1'b0, 1'b0);
    host_write(8'hA5);
    mw[0] = 8'h3C;
    run_frame(1, 0);

    // Modes 1..3 LSB first, two back-to-back words.
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      if (m == 1) begin
        host_write(8'h81); host_write(8'h42);
        mw[0] = 8'h0F; mw[1] = 8'hF0;
      end else begin
        host_write(8'($urandom_range(0, 255))); host_write(8'($urandom_range(0, 255)));
        mw[0] = 8'($urandom_range(0, 255)); mw[1] = 8'($urandom_range(0, 255));
      end
      run_frame(2, 0);
    end

    // RX overflow: five words with the host not popping.
    set_mode(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    host_if.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) mw[i] = 8'($urandom_range(0, 255));
    run_frame(5, 0);
    chk("rx_level_full", host_if.rx_level, 4);
    @(posedge clk); #1;
    host_if.rx_ready = 1'b1;
    for (int i = 0; i < 50 && host_if.rx_level != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("rx_drained", host_if.rx_level, 0);
    chk("rx_exp_drained", exp_rx.size(), 0);

    // Block disabled: ssn is ignored, host side still works.
    @(posedge clk); #1;
    slave_mode = 1'b0;
    host_write(8'($urandom_range(0, 255)));
    ssn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_disabled", busy, 0);
    chk("oe_disabled", miso_oe, 0);
    ssn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    slave_mode = 1'b1;
    chk("tx_level_disabled", host_if.tx_level, tx_model.size());

    // Partial word: ssn raised after 3 bits.
    fe_cnt = 0;
    mw[0] = 8'($urandom_range(0, 255));
    run_frame(1, 3);
    chk("partial_rx_level", host_if.rx_level, 0);
    chk("partial_frame_err", fe_cnt, ExpFe);

    // Reset mid-word, then a clean frame.
    host_write(8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    ssn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      mosi = 1'($urandom_range(0, 1));
      half(); sck = 1'b1; half(); sck = 1'b0;
    end
    half(); sck = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; ssn = 1'b1; sck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    tx_model.delete(); exp_rx.delete();
    exp_underrun = 1'b0; exp_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    host_write(8'($urandom_range(0, 255)));
    mw[0] = 8'($urandom_range(0, 255));
    run_frame(1, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
